// File: rtl/instr_align_if.sv
// -----------------------------------------------------------------------------
// instr_align_if
//   Bundles the fetch-side handshake and the D-stage output of instr_align.
//
//   Fetch side : FetchWordF, FetchAddrF, FetchValidF -> / <- FetchReadyF
//   Control    : FlushD, RedirectPCF, StallD
//   D stage    : InstrRawD, PCD, CompressedD, InstrValidD
//
//   master : the fetch/pipeline side that drives the aligner
//   slave  : the aligner itself
// -----------------------------------------------------------------------------
interface instr_align_if #(
    parameter int XLEN = 64
);
    logic [31:0]     FetchWordF;
    logic [XLEN-1:0] FetchAddrF;
    logic            FetchValidF;
    logic            FetchReadyF;
    logic            FlushD;
    logic [XLEN-1:0] RedirectPCF;
    logic            StallD;
    logic [31:0]     InstrRawD;
    logic [XLEN-1:0] PCD;
    logic            CompressedD;
    logic            InstrValidD;

    modport master (
        output FetchWordF, FetchAddrF, FetchValidF, FlushD, RedirectPCF, StallD,
        input  FetchReadyF, InstrRawD, PCD, CompressedD, InstrValidD
    );

    modport slave (
        input  FetchWordF, FetchAddrF, FetchValidF, FlushD, RedirectPCF, StallD,
        output FetchReadyF, InstrRawD, PCD, CompressedD, InstrValidD
    );
endinterface

// File: rtl/instr_align.sv
// -----------------------------------------------------------------------------
// instr_align
//   Turns a stream of word-aligned 32-bit fetch words into one instruction per
//   cycle for the decompress stage. Output is registered (1-cycle latency).
//
//   Build option: INSTR_ALIGN_ZCA_EN
//     defined   - compressed (16-bit) support: pairs, straddling 32-bit
//                 instructions, redirects to halfword targets.
//     undefined - every accepted word is emitted whole, CompressedD=0, no
//                 residue storage; RedirectPCF is ignored.
//
//   Ports
//     clk     : clock
//     reset   : asynchronous active-low reset
//     io_bus  : instr_align_if.slave (fetch handshake, flush/stall, D outputs)
// -----------------------------------------------------------------------------
module instr_align #(
    parameter int XLEN = 64
) (
    input  logic           clk,
    input  logic           reset,
    instr_align_if.slave   io_bus
);

    logic            w_adv;
    logic            w_ready;
    logic            w_accept;
    logic            w_emit;
    logic [31:0]     w_instr;
    logic [XLEN-1:0] w_pc;
    logic            w_comp;

    logic            r_valid;
    logic [31:0]     r_instr;
    logic [XLEN-1:0] r_pc;
    logic            r_comp;

    assign w_adv = !io_bus.StallD;

`ifdef INSTR_ALIGN_ZCA_EN
    typedef enum logic [1:0] {EMPTY, SKIP, HALF} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [15:0]     r_res;
    logic [XLEN-1:0] r_res_pc;
    logic            w_res_load;

    logic [15:0]     w_lo;
    logic [15:0]     w_hi;
    logic            w_lo_c;   // low half of the fetch word is compressed
    logic            w_res_c;  // residue halfword is a complete compressed instr

    assign w_lo    = io_bus.FetchWordF[15:0];
    assign w_hi    = io_bus.FetchWordF[31:16];
    assign w_lo_c  = (w_lo[1:0] != 2'b11);
    assign w_res_c = (r_res[1:0] != 2'b11);

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_state <= EMPTY;
        else
            r_state <= w_state_nxt;
    end

    // next state
    always_comb begin
        w_state_nxt = r_state;
        if (io_bus.FlushD) begin
            w_state_nxt = io_bus.RedirectPCF[1] ? SKIP : EMPTY;
        end else begin
            case (r_state)
                EMPTY:   if (w_res_load)          w_state_nxt = HALF;
                SKIP:    if (w_accept)            w_state_nxt = HALF;
                HALF:    if (w_res_c && w_adv)    w_state_nxt = EMPTY;
                default:                          w_state_nxt = EMPTY;
            endcase
        end
    end

    // outputs: fetch handshake, what to emit, whether to refill the residue
    always_comb begin
        w_ready    = 1'b0;
        w_accept   = 1'b0;
        w_emit     = 1'b0;
        w_res_load = 1'b0;
        w_instr    = '0;
        w_pc       = '0;
        if (!io_bus.FlushD) begin
            case (r_state)
                EMPTY: begin
                    w_ready    = w_adv;
                    w_accept   = io_bus.FetchValidF && w_ready;
                    w_emit     = w_accept;
                    w_res_load = w_accept && w_lo_c;
                    w_instr    = w_lo_c ? {16'h0, w_lo} : io_bus.FetchWordF;
                    w_pc       = io_bus.FetchAddrF;
                end
                SKIP: begin
                    // redirect landed on the upper half: drop the low half
                    w_ready    = w_adv;
                    w_accept   = io_bus.FetchValidF && w_ready;
                    w_res_load = w_accept;
                end
                HALF: begin
                    w_pc = r_res_pc;
                    if (w_res_c) begin
                        // residue is a whole instruction; drain it without fetching
                        w_emit  = w_adv;
                        w_instr = {16'h0, r_res};
                    end else begin
                        // residue is the low half of a 32-bit instr straddling words
                        w_ready    = w_adv;
                        w_accept   = io_bus.FetchValidF && w_ready;
                        w_emit     = w_accept;
                        w_res_load = w_accept;
                        w_instr    = {w_lo, r_res};
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_res    <= '0;
            r_res_pc <= '0;
        end else if (w_res_load) begin
            r_res    <= w_hi;
            r_res_pc <= io_bus.FetchAddrF + XLEN'(2);
        end
    end

    assign w_comp = (w_instr[1:0] != 2'b11);

    logic w_unused;
    assign w_unused = ^{io_bus.RedirectPCF[XLEN-1:2], io_bus.RedirectPCF[0]};
`else
    assign w_ready  = w_adv && !io_bus.FlushD;
    assign w_accept = io_bus.FetchValidF && w_ready;
    assign w_emit   = w_accept;
    assign w_instr  = io_bus.FetchWordF;
    assign w_pc     = io_bus.FetchAddrF;
    assign w_comp   = 1'b0;

    logic w_unused;
    assign w_unused = ^io_bus.RedirectPCF;
`endif

    // D-stage register; flush kills valid but leaves the data fields alone
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_instr <= '0;
            r_pc    <= '0;
            r_comp  <= 1'b0;
        end else if (io_bus.FlushD) begin
            r_valid <= 1'b0;
        end else if (w_adv) begin
            r_valid <= w_emit;
            if (w_emit) begin
                r_instr <= w_instr;
                r_pc    <= w_pc;
                r_comp  <= w_comp;
            end
        end
    end

    assign io_bus.FetchReadyF = w_ready;
    assign io_bus.InstrValidD = r_valid;
    assign io_bus.InstrRawD   = r_instr;
    assign io_bus.PCD         = r_pc;
    assign io_bus.CompressedD = r_comp;

endmodule

// File: tb/tb_instr_align.sv
// Directed-vector bench for instr_align. Expectations follow the build option
// INSTR_ALIGN_ZCA_EN (compressed support) when it is defined.
module tb_instr_align;

    localparam int XLEN = 64;

    logic clk;
    logic reset;

    instr_align_if #(.XLEN(XLEN)) bus ();

    instr_align #(.XLEN(XLEN)) dut (
        .clk    (clk),
        .reset  (reset),
        .io_bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic            vld;
        logic [31:0]     word;
        logic [63:0]     addr;
        logic            stall;
        logic            flush;
        logic [63:0]     redir;
        logic            e_rdy;
        logic            e_vld;
        logic [31:0]     e_raw;
        logic [63:0]     e_pc;
        logic            e_cmp;
    } vec_t;

    vec_t tv[$];
    int   n_pass = 0;
    int   n_tot  = 0;

    function automatic vec_t mk(logic vld, logic [31:0] word, logic [63:0] addr,
                                logic stall, logic flush, logic [63:0] redir,
                                logic e_rdy, logic e_vld, logic [31:0] e_raw,
                                logic [63:0] e_pc, logic e_cmp);
        vec_t v;
        v.vld = vld; v.word = word; v.addr = addr; v.stall = stall;
        v.flush = flush; v.redir = redir; v.e_rdy = e_rdy; v.e_vld = e_vld;
        v.e_raw = e_raw; v.e_pc = e_pc; v.e_cmp = e_cmp;
        return v;
    endfunction

    task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
        n_tot++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", nm, got, exp);
    endtask

    task automatic drive(vec_t v);
        bus.FetchValidF = v.vld;
        bus.FetchWordF  = v.word;
        bus.FetchAddrF  = v.addr;
        bus.StallD      = v.stall;
        bus.FlushD      = v.flush;
        bus.RedirectPCF = v.redir;
    endtask

    // drive at negedge, check the combinational ready, then the registered
    // outputs just after the capturing posedge
    task automatic run_vec(string tag, vec_t v);
        @(negedge clk);
        drive(v);
        #1;
        chk({tag, " ready"}, 64'(bus.FetchReadyF), 64'(v.e_rdy));
        @(posedge clk);
        #1;
        chk({tag, " ivalid"}, 64'(bus.InstrValidD), 64'(v.e_vld));
        chk({tag, " raw"},    64'(bus.InstrRawD),   64'(v.e_raw));
        chk({tag, " pc"},     bus.PCD,              v.e_pc);
        chk({tag, " comp"},   64'(bus.CompressedD), 64'(v.e_cmp));
    endtask

    localparam logic [63:0] TOP = 64'hFFFF_FFFF_FFFF_FFFC;

    initial begin
        vec_t idle;
        idle = mk(0, 32'h0, 64'h0, 0, 0, 64'h0, 0, 0, 32'h0, 64'h0, 0);
        reset = 1'b0;
        drive(idle);

        // ------------------------------------------------------------------
        // vector table
        //        vld word          addr        stl fls redir     rdy ivl raw           pc          cmp
`ifdef INSTR_ALIGN_ZCA_EN
        tv.push_back(mk(0, 32'h0,          64'h0,    0, 0, 64'h0,    1, 0, 32'h0,          64'h0,    0));
        tv.push_back(mk(1, 32'h00A5_0513, 64'h1000, 0, 0, 64'h0,    1, 1, 32'h00A5_0513, 64'h1000, 0));
        // compressed pair: second half drains with ready low, word is held off
        tv.push_back(mk(1, 32'h4585_4505, 64'h2000, 0, 0, 64'h0,    1, 1, 32'h0000_4505, 64'h2000, 1));
        tv.push_back(mk(1, 32'h00A5_0513, 64'h2004, 0, 0, 64'h0,    0, 1, 32'h0000_4585, 64'h2002, 1));
        tv.push_back(mk(1, 32'h00A5_0513, 64'h2004, 0, 0, 64'h0,    1, 1, 32'h00A5_0513, 64'h2004, 0));
        // straddle
        tv.push_back(mk(1, 32'h0513_4505, 64'h3000, 0, 0, 64'h0,    1, 1, 32'h0000_4505, 64'h3000, 1));
        tv.push_back(mk(1, 32'h1234_00A5, 64'h3004, 0, 0, 64'h0,    1, 1, 32'h00A5_0513, 64'h3002, 0));
        tv.push_back(mk(0, 32'h0,          64'h0,    0, 0, 64'h0,    0, 1, 32'h0000_1234, 64'h3006, 1));
        // straddle with the second word late: bubble, data held
        tv.push_back(mk(1, 32'h0513_4505, 64'h3008, 0, 0, 64'h0,    1, 1, 32'h0000_4505, 64'h3008, 1));
        tv.push_back(mk(0, 32'h0,          64'h0,    0, 0, 64'h0,    1, 0, 32'h0000_4505, 64'h3008, 1));
        tv.push_back(mk(1, 32'h0001_00A5, 64'h300C, 0, 0, 64'h0,    1, 1, 32'h00A5_0513, 64'h300A, 0));
        tv.push_back(mk(0, 32'h0,          64'h0,    0, 0, 64'h0,    0, 1, 32'h0000_0001, 64'h300E, 1));
        // flush to halfword target; presented word dropped
        tv.push_back(mk(1, 32'h0000_0013, 64'h3010, 0, 1, 64'h4002, 0, 0, 32'h0000_0001, 64'h300E, 1));
        tv.push_back(mk(1, 32'h4505_FFFF, 64'h4000, 0, 0, 64'h0,    1, 0, 32'h0000_0001, 64'h300E, 1));
        tv.push_back(mk(0, 32'h0,          64'h0,    0, 0, 64'h0,    0, 1, 32'h0000_4505, 64'h4002, 1));
        // stall for 3 cycles inside a compressed pair
        tv.push_back(mk(1, 32'h4585_4505, 64'h2000, 0, 0, 64'h0,    1, 1, 32'h0000_4505, 64'h2000, 1));
        tv.push_back(mk(1, 32'h1111_1111, 64'h2004, 1, 0, 64'h0,    0, 1, 32'h0000_4505, 64'h2000, 1));
        tv.push_back(mk(1, 32'h1111_1111, 64'h2004, 1, 0, 64'h0,    0, 1, 32'h0000_4505, 64'h2000, 1));
        tv.push_back(mk(1, 32'h1111_1111, 64'h2004, 1, 0, 64'h0,    0, 1, 32'h0000_4505, 64'h2000, 1));
        tv.push_back(mk(0, 32'h0,          64'h0,    0, 0, 64'h0,    0, 1, 32'h0000_4585, 64'h2002, 1));
        // flush beats stall
        tv.push_back(mk(1, 32'h0000_0013, 64'h2004, 1, 1, 64'h0,    0, 0, 32'h0000_4585, 64'h2002, 1));
        // top of address space
        tv.push_back(mk(1, 32'h0000_4505, TOP,      0, 0, 64'h0,    1, 1, 32'h0000_4505, TOP,      1));
        tv.push_back(mk(0, 32'h0,          64'h0,    0, 0, 64'h0,    0, 1, 32'h0000_0000, TOP + 64'd2, 1));
`else
        tv.push_back(mk(0, 32'h0,          64'h0,    0, 0, 64'h0,    1, 0, 32'h0,          64'h0,    0));
        tv.push_back(mk(1, 32'h00A5_0513, 64'h1000, 0, 0, 64'h0,    1, 1, 32'h00A5_0513, 64'h1000, 0));
        tv.push_back(mk(1, 32'h4585_4505, 64'h2000, 0, 0, 64'h0,    1, 1, 32'h4585_4505, 64'h2000, 0));
        tv.push_back(mk(0, 32'h0,          64'h0,    0, 0, 64'h0,    1, 0, 32'h4585_4505, 64'h2000, 0));
        tv.push_back(mk(1, 32'h0513_4505, 64'h3000, 0, 0, 64'h0,    1, 1, 32'h0513_4505, 64'h3000, 0));
        tv.push_back(mk(1, 32'h1234_00A5, 64'h3004, 1, 0, 64'h0,    0, 1, 32'h0513_4505, 64'h3000, 0));
        tv.push_back(mk(1, 32'h1234_00A5, 64'h3004, 1, 0, 64'h0,    0, 1, 32'h0513_4505, 64'h3000, 0));
        tv.push_back(mk(1, 32'h1234_00A5, 64'h3004, 0, 0, 64'h0,    1, 1, 32'h1234_00A5, 64'h3004, 0));
        tv.push_back(mk(1, 32'h4505_FFFF, 64'h4000, 0, 1, 64'h4002, 0, 0, 32'h1234_00A5, 64'h3004, 0));
        tv.push_back(mk(1, 32'h4505_FFFF, 64'h4000, 0, 0, 64'h0,    1, 1, 32'h4505_FFFF, 64'h4000, 0));
        tv.push_back(mk(1, 32'h0000_0013, 64'h4004, 1, 1, 64'h0,    0, 0, 32'h4505_FFFF, 64'h4000, 0));
        tv.push_back(mk(1, 32'h0000_0013, TOP,      0, 0, 64'h0,    1, 1, 32'h0000_0013, TOP,      0));
`endif

        // ------------------------------------------------------------------
        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst ivalid", 64'(bus.InstrValidD), 64'd0);
        chk("rst raw",    64'(bus.InstrRawD),   64'd0);
        chk("rst pc",     bus.PCD,              64'd0);
        chk("rst comp",   64'(bus.CompressedD), 64'd0);
        chk("rst ready",  64'(bus.FetchReadyF), 64'd1);
        reset = 1'b1;

        foreach (tv[i])
            run_vec($sformatf("v%0d", i), tv[i]);

        // ------------------------------------------------------------------
        // asynchronous reset in the middle of a compressed pair
        run_vec("mr0", mk(1, 32'h4585_4505, 64'h2000, 0, 0, 64'h0, 1, 1,
`ifdef INSTR_ALIGN_ZCA_EN
                          32'h0000_4505, 64'h2000, 1));
`else
                          32'h4585_4505, 64'h2000, 0));
`endif
        @(negedge clk);
        drive(idle);
        reset = 1'b0;
        #1;
        chk("mr ivalid", 64'(bus.InstrValidD), 64'd0);
        chk("mr raw",    64'(bus.InstrRawD),   64'd0);
        chk("mr pc",     bus.PCD,              64'd0);
        chk("mr comp",   64'(bus.CompressedD), 64'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        // residue lost: the next word is taken as if from EMPTY
        run_vec("mr1", mk(1, 32'h00A5_0513, 64'h5000, 0, 0, 64'h0, 1, 1, 32'h00A5_0513, 64'h5000, 0));
        run_vec("mr2", mk(0, 32'h0, 64'h0, 0, 0, 64'h0, 1, 0, 32'h00A5_0513, 64'h5000, 0));

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
